char_line_writer: RTL and testbench
===================================

# char_line_writer

Renders one text line of NCHAR 4-bit character codes into a stream of 8-bit pixel columns for the oscilloscope display. It sits directly upstream of the `char_set` glyph ROM stage. For each character it drives the code into `char_set`, waits for the registered glyph, captures the 7 columns, and emits them one byte per beat on a valid/ready stream to the display write path.

## Interface
- `NCHAR`, 16: characters per line (≥1); code i occupies `text[4*i+3:4*i]`
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle request to render `text`
- `text`  in  4*NCHAR  packed character codes, char 0 in LSBs
- `busy`  out  1  high from start acceptance until line complete
- `done`  out  1  one-cycle pulse after last column accepted
- `char_data`  out  4  registered code to `char_set.data`
- `col0`..`col6`  in  8 each  glyph columns returned by `char_set` (one-cycle registered latency)
- `col_data`  out  8  pixel column, bit0 = top row
- `col_valid`  out  1  `col_data` valid
- `col_ready`  in  1  consumer accepts when high with `col_valid`
- `col_addr`  out  $clog2(7*NCHAR)  column index within line, 0-based
- `col_last`  out  1  high on the final column of the line
- `invert`  in  NCHAR  per-character inversion (only with `CHAR_LINE_INVERT_EN`)

## Operation
- FSM states: IDLE, WAIT1, WAIT2, EMIT, DONE.
- IDLE:
  - On `start`, latch `text` (and `invert`).
  - Set `char_data <= code0`, char index 0, column index 0, `busy <= 1`.
  - Go to WAIT1.
- WAIT1: `char_set` registers the glyph. Go to WAIT2.
- WAIT2: capture `col0`..`col6` into a 7×8 local buffer. Set `col_valid <= 1`. Go to EMIT.
- EMIT:
  - `col_data` = `buffer[column index]`.
  - On each accept (`col_valid & col_ready`), advance the column index and `col_addr`.
  - When the accepted beat is column 6 and the character is not last: `col_valid <= 0`, `char_data <=` next code, go to WAIT1.
  - When the accepted beat is column 6 of the last character: go to DONE.
- DONE: `done <= 1` for one cycle, `busy <= 0`, return to IDLE.
- Valid/ready rules:
  - Once `col_valid` is high, `col_data`, `col_addr` and `col_last` stay stable until accepted.
  - `col_valid` never drops without an accept.
- `col_last` = (char index == NCHAR-1) && (column == 6).
- `start` while busy is ignored. Latched text is unaffected by later changes to `text`.
- Codes are passed through unchanged. Code 0 renders the `char_set` default glyph.
- `col_addr` = 7*char + column. It never wraps within a line and returns to 0 in IDLE.

## Timing
- Reset (`rst` high at a rising edge) forces:
  - state IDLE
  - `busy`, `done`, `col_valid`, `col_last` = 0
  - `col_data`, `col_addr` = 0
  - `char_data` = 4'd13 (blank)
- Reset mid-line aborts the line with no `done` pulse. `col_valid` drops on that edge.
- With `start` sampled at edge 0 and `col_ready` tied high:
  - first `col_valid` is high after edge 2
  - char 0 beats are accepted at edges 3..9
  - each character costs 9 edges (7 beats plus 2 glyph-fetch cycles)
  - the last beat is accepted at edge 9*NCHAR
  - `done` is high for the cycle after that edge
  - `busy` drops at the same time `done` rises
- Backpressure: `col_ready` low stalls EMIT indefinitely with no data loss. Glyph fetch cycles do not depend on `col_ready`.
- `start` arriving in the same cycle as `done` is ignored. The earliest restart is the following cycle.

## Configuration
- `CHAR_LINE_INVERT_EN` defined:
  - the `invert` port exists and is latched at start
  - columns of char i are emitted as `~buffer[c]` when `invert[i]` is set (menu/cursor highlight)
- `CHAR_LINE_INVERT_EN` undefined: the port is absent and columns are never inverted. Timing is identical in both builds.

## Structure
- Package `char_line_pkg` holds:
  - `GLYPH_COLS = 7`, `GLYPH_ROWS = 8`, `CODE_W = 4`
  - code constants `CH_BLANK = 13`, `CH_COLON = 14`
  - the FSM state enum
- Single module, no sub-module. The glyph buffer and column mux are inline.

## Test plan
- NCHAR=2, text = {2, 1} ("FH"), ready high → columns 00,7F,09,09,09,01,00,00,7F,08,08,08,7F,00 with `col_addr` 0..13; `col_last` only on addr 13; `done` one cycle after edge 18.
- Same text, `col_ready` toggled 1,0,0,1 repeating → identical byte sequence; no duplicate or dropped columns; data stable while stalled.
- `start` pulsed again at edge 5 and `text` changed at edge 5 → ignored; output still "FH".
- `rst` asserted at edge 12 → `col_valid`, `busy` = 0 next cycle; `char_data` = 13; no `done`; a new `start` renders from addr 0.
- With `CHAR_LINE_INVERT_EN`, text {3} ("I"), `invert` = 1 → FF,FF,BE,80,BE,FF,FF.
- Code 0 in position 0 → default glyph 00,22,14,08,14,22,00.

Source files
------------

// File: rtl/char_line_writer_pkg.sv
// Shared constants and FSM state type for the character line renderer.
package char_line_pkg;

  localparam int GLYPH_COLS = 7;
  localparam int GLYPH_ROWS = 8;
  localparam int CODE_W     = 4;

  localparam logic [CODE_W-1:0] CH_BLANK = 4'd13;
  localparam logic [CODE_W-1:0] CH_COLON = 4'd14;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT1 = 3'd1,
    ST_WAIT2 = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/char_line_writer_if.sv
// Pixel-column valid/ready stream from the line renderer to the display write path.
interface char_line_writer_if #(
  parameter int NCHAR = 16
);
  import char_line_pkg::*;

  localparam int ADDR_W = $clog2(GLYPH_COLS * NCHAR);

  logic [GLYPH_ROWS-1:0] col_data;
  logic                  col_valid;
  logic                  col_ready;
  logic [ADDR_W-1:0]     col_addr;
  logic                  col_last;

  modport master (
    output col_data, col_valid, col_addr, col_last,
    input  col_ready
  );

  modport slave (
    input  col_data, col_valid, col_addr, col_last,
    output col_ready
  );

endinterface

// File: rtl/char_line_writer.sv
// Renders NCHAR character codes into a stream of glyph columns via the char_set ROM.
// Optional per-character highlight inversion is enabled by defining CHAR_LINE_INVERT_EN.
module char_line_writer
  import char_line_pkg::*;
#(
  parameter int NCHAR = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CODE_W*NCHAR-1:0] text,
`ifdef CHAR_LINE_INVERT_EN
  input  logic [NCHAR-1:0]        invert,
`endif
  output logic                    busy,
  output logic                    done,
  output logic [CODE_W-1:0]       char_data,
  input  logic [GLYPH_ROWS-1:0]   col0,
  input  logic [GLYPH_ROWS-1:0]   col1,
  input  logic [GLYPH_ROWS-1:0]   col2,
  input  logic [GLYPH_ROWS-1:0]   col3,
  input  logic [GLYPH_ROWS-1:0]   col4,
  input  logic [GLYPH_ROWS-1:0]   col5,
  input  logic [GLYPH_ROWS-1:0]   col6,
  char_line_writer_if.master      col
);

  localparam int         CHAR_W   = (NCHAR > 1) ? $clog2(NCHAR) : 1;
  localparam int         ADDR_W   = $clog2(GLYPH_COLS * NCHAR);
  localparam logic [2:0] LAST_COL = 3'(GLYPH_COLS - 1);

  state_t                  state_r;
  logic [CODE_W*NCHAR-1:0] text_r;
  logic [GLYPH_ROWS-1:0]   buf_r [GLYPH_COLS];
  logic [CHAR_W-1:0]       char_idx_r;
  logic [2:0]              col_idx_r;
`ifdef CHAR_LINE_INVERT_EN
  logic [NCHAR-1:0]        invert_r;
`endif

  logic [CHAR_W-1:0]       char_nxt_s;
  logic [2:0]              col_nxt_s;
  logic                    last_char_s;
  logic                    accept_s;
  logic [CODE_W-1:0]       next_code_s;
  logic [GLYPH_ROWS-1:0]   inv_mask_s;

  // Next-character / next-column selection and highlight mask for the current character
  always_comb begin
    char_nxt_s  = char_idx_r + CHAR_W'(1);
    col_nxt_s   = col_idx_r + 3'd1;
    last_char_s = (char_idx_r == CHAR_W'(NCHAR - 1));
    accept_s    = col.col_valid & col.col_ready;
    next_code_s = text_r[CODE_W*char_nxt_s +: CODE_W];
`ifdef CHAR_LINE_INVERT_EN
    inv_mask_s  = {GLYPH_ROWS{invert_r[char_idx_r]}};
`else
    inv_mask_s  = {GLYPH_ROWS{1'b0}};
`endif
  end

  // Line sequencer: glyph fetch, column capture and stream emission
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      char_data     <= CH_BLANK;
      col.col_valid <= 1'b0;
      col.col_last  <= 1'b0;
      col.col_data  <= {GLYPH_ROWS{1'b0}};
      col.col_addr  <= {ADDR_W{1'b0}};
      text_r        <= {(CODE_W*NCHAR){1'b0}};
      char_idx_r    <= {CHAR_W{1'b0}};
      col_idx_r     <= 3'd0;
`ifdef CHAR_LINE_INVERT_EN
      invert_r      <= {NCHAR{1'b0}};
`endif
      for (int i = 0; i < GLYPH_COLS; i++) begin
        buf_r[i] <= {GLYPH_ROWS{1'b0}};
      end
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          col.col_addr <= {ADDR_W{1'b0}};
          if (start) begin
            text_r     <= text;
`ifdef CHAR_LINE_INVERT_EN
            invert_r   <= invert;
`endif
            char_data  <= text[CODE_W-1:0];
            char_idx_r <= {CHAR_W{1'b0}};
            col_idx_r  <= 3'd0;
            busy       <= 1'b1;
            state_r    <= ST_WAIT1;
          end
        end
        ST_WAIT1: begin
          state_r <= ST_WAIT2;
        end
        ST_WAIT2: begin
          buf_r[0]      <= col0;
          buf_r[1]      <= col1;
          buf_r[2]      <= col2;
          buf_r[3]      <= col3;
          buf_r[4]      <= col4;
          buf_r[5]      <= col5;
          buf_r[6]      <= col6;
          col.col_data  <= col0 ^ inv_mask_s;
          col.col_last  <= 1'b0;
          col.col_valid <= 1'b1;
          col_idx_r     <= 3'd0;
          state_r       <= ST_EMIT;
        end
        ST_EMIT: begin
          if (accept_s) begin
            if (col_idx_r == LAST_COL) begin
              col.col_valid <= 1'b0;
              col.col_last  <= 1'b0;
              if (last_char_s) begin
                col.col_addr <= {ADDR_W{1'b0}};
                done         <= 1'b1;
                busy         <= 1'b0;
                state_r      <= ST_DONE;
              end else begin
                col.col_addr <= col.col_addr + ADDR_W'(1);
                char_idx_r   <= char_nxt_s;
                char_data    <= next_code_s;
                state_r      <= ST_WAIT1;
              end
            end else begin
              // Next beat is loaded only on accept, so the held beat stays stable under stall
              col_idx_r    <= col_nxt_s;
              col.col_addr <= col.col_addr + ADDR_W'(1);
              col.col_data <= buf_r[col_nxt_s] ^ inv_mask_s;
              col.col_last <= last_char_s & (col_nxt_s == LAST_COL);
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_line_writer.sv
// Randomized self-checking bench for char_line_writer with a behavioural char_set model.
module tb_char_line_writer;
  import char_line_pkg::*;

  localparam int NCHAR = 2;
  localparam int TW    = 4 * NCHAR;
`ifdef CHAR_LINE_INVERT_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] d;
    int         a;
    bit         l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [TW-1:0] text;
`ifdef CHAR_LINE_INVERT_EN
  logic [NCHAR-1:0] invert;
`endif
  logic          busy;
  logic          done;
  logic [3:0]    char_data;
  logic [7:0]    col0, col1, col2, col3, col4, col5, col6;

  int checks = 0;
  int errors = 0;

  char_line_writer_if #(.NCHAR(NCHAR)) col_if ();

  always #5 clk = ~clk;

  char_line_writer #(.NCHAR(NCHAR)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .text      (text),
`ifdef CHAR_LINE_INVERT_EN
    .invert    (invert),
`endif
    .busy      (busy),
    .done      (done),
    .char_data (char_data),
    .col0      (col0),
    .col1      (col1),
    .col2      (col2),
    .col3      (col3),
    .col4      (col4),
    .col5      (col5),
    .col6      (col6),
    .col       (col_if)
  );

  // Glyph table of the char_set ROM; column 0 is the leftmost byte
  function automatic logic [7:0] glyph(input logic [3:0] code, input int c);
    logic [55:0] row;
    case (code)
      4'd0:    row = 56'h00_22_14_08_14_22_00;
      4'd1:    row = 56'h00_7F_09_09_09_01_00;
      4'd2:    row = 56'h00_7F_08_08_08_7F_00;
      4'd3:    row = 56'h00_00_41_7F_41_00_00;
      4'd13:   row = 56'h00_00_00_00_00_00_00;
      4'd14:   row = 56'h00_00_36_36_00_00_00;
      default: row = {7{code, 4'h5}} ^ 56'h01_02_04_08_10_20_40;
    endcase
    return row[8*(6-c) +: 8];
  endfunction

  // char_set model: one-cycle registered glyph lookup
  always_ff @(posedge clk) begin
    col0 <= glyph(char_data, 0);
    col1 <= glyph(char_data, 1);
    col2 <= glyph(char_data, 2);
    col3 <= glyph(char_data, 3);
    col4 <= glyph(char_data, 4);
    col5 <= glyph(char_data, 5);
    col6 <= glyph(char_data, 6);
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode: 0 ready high, 1 ready pattern 1,0,0,1, 2 random ready
  task automatic run_line(input logic [TW-1:0] txt, input logic [NCHAR-1:0] inv,
                          input int mode, input bit poke5, input bit rst12);
    beat_t q[$];
    beat_t b;
    beat_t held;
    bit    stalled;
    bit    r;
    int    nbeats, done_edge, first_acc, last_acc;
    q.delete();
    for (int i = 0; i < NCHAR; i++) begin
      for (int c = 0; c < 7; c++) begin
        b.d = glyph(txt[4*i +: 4], c) ^ {8{INV_EN && inv[i]}};
        b.a = 7 * i + c;
        b.l = (i == NCHAR - 1) && (c == 6);
        q.push_back(b);
      end
    end
    held = '{d: 8'h00, a: 0, l: 1'b0};
    @(negedge clk);
    start = 1'b1;
    text  = txt;
`ifdef CHAR_LINE_INVERT_EN
    invert = inv;
`endif
    col_if.col_ready = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    stalled   = 1'b0;
    nbeats    = 0;
    done_edge = -1;
    first_acc = -1;
    last_acc  = -1;
    for (int k = 1; k <= 400 && done_edge < 0 && !(rst12 && k > 20); k++) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = ((k - 1) % 4 == 0) || ((k - 1) % 4 == 3);
        default: r = ($urandom_range(0, 2) != 0);
      endcase
      col_if.col_ready = r;
      start = poke5 && (k == 5);
      if (poke5 && k == 5) begin
        text = ~txt;
`ifdef CHAR_LINE_INVERT_EN
        invert = ~inv;
`endif
      end
      rst = rst12 && (k == 12);
      @(negedge clk);
      if (k == 1) check_eq("busy_after_start", int'(busy), 1);
      if (rst12 && k == 13) begin
        check_eq("rst_valid", int'(col_if.col_valid), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_char_data", int'(char_data), 13);
        check_eq("rst_addr", int'(col_if.col_addr), 0);
      end
      if (rst12 && k > 12) check_eq("rst_no_done", int'(done), 0);
      if (done) begin
        check_eq("busy_at_done", int'(busy), 0);
        done_edge = k - 1;
      end else begin
        if (stalled && !(rst12 && k == 13)) begin
          check_eq("stall_valid", int'(col_if.col_valid), 1);
          check_eq("stall_data", int'(col_if.col_data), int'(held.d));
          check_eq("stall_addr", int'(col_if.col_addr), held.a);
          check_eq("stall_last", int'(col_if.col_last), int'(held.l));
        end
        if (col_if.col_valid && col_if.col_ready) begin
          if (q.size() == 0) begin
            check_eq("beat_overflow", q.size(), 1);
          end else begin
            b = q.pop_front();
            check_eq("col_data", int'(col_if.col_data), int'(b.d));
            check_eq("col_addr", int'(col_if.col_addr), b.a);
            check_eq("col_last", int'(col_if.col_last), int'(b.l));
          end
          nbeats++;
          if (first_acc < 0) first_acc = k;
          last_acc = k;
        end
        stalled = col_if.col_valid && !col_if.col_ready;
        held    = '{d: col_if.col_data, a: int'(col_if.col_addr), l: col_if.col_last};
      end
      if (done_edge < 0) begin
        @(posedge clk);
        #1;
      end
    end
    rst = 1'b0;
    if (!rst12) begin
      check_eq("done_seen", int'(done_edge >= 0), 1);
      check_eq("beats_left", q.size(), 0);
      check_eq("beat_count", nbeats, 7 * NCHAR);
      if (mode == 0) begin
        check_eq("first_accept_edge", first_acc, 3);
        check_eq("last_accept_edge", last_acc, 9 * NCHAR);
        check_eq("done_edge", done_edge, 9 * NCHAR);
      end
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [TW-1:0]    rt;
    logic [NCHAR-1:0] ri;
    rst   = 1'b1;
    start = 1'b0;
    text  = {TW{1'b0}};
`ifdef CHAR_LINE_INVERT_EN
    invert = {NCHAR{1'b0}};
`endif
    col_if.col_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_busy", int'(busy), 0);
    check_eq("reset_done", int'(done), 0);
    check_eq("reset_valid", int'(col_if.col_valid), 0);
    check_eq("reset_last", int'(col_if.col_last), 0);
    check_eq("reset_data", int'(col_if.col_data), 0);
    check_eq("reset_addr", int'(col_if.col_addr), 0);
    check_eq("reset_char_data", int'(char_data), 13);
    rst = 1'b0;

    run_line(8'h21, 2'b00, 0, 1'b0, 1'b0);
    // start sampled in the cycle that done is high must be ignored
    start = 1'b1;
    text  = 8'h33;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("start_in_done_busy", int'(busy), 0);
    check_eq("done_single_cycle", int'(done), 0);

    run_line(8'h21, 2'b00, 1, 1'b0, 1'b0);
    run_line(8'h21, 2'b00, 0, 1'b1, 1'b0);
    run_line(8'h21, 2'b00, 0, 1'b0, 1'b1);
    run_line(8'h21, 2'b00, 0, 1'b0, 1'b0);
    run_line(8'h20, 2'b00, 0, 1'b0, 1'b0);
    run_line(8'h03, 2'b01, 0, 1'b0, 1'b0);
    for (int n = 0; n < 10; n++) begin
      rt = TW'($urandom);
      ri = NCHAR'($urandom);
      run_line(rt, ri, 2, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
